// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bi, bo = borrow out.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_sub_cell sequenced LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-2:0] res;
  logic             borrow;
  logic             cell_d, cell_bo;
  logic             last_bit;

  full_sub_cell u_cell (
    .x  (a_reg[0]),
    .y  (b_reg[0]),
    .bi (borrow),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign last_bit = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Partial result holds the low WIDTH-1 bits; the final cell output becomes the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      res    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        S_RUN: begin
          res    <= (WIDTH-1)'({cell_d, res} >> 1);
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          borrow <= cell_bo;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            diff <= {cell_d, res};
            bout <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
            // Signed overflow: borrow into the MSB differs from borrow out of it.
            ovf  <= borrow ^ cell_bo;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl (WIDTH=8 and WIDTH=3) and full_sub_cell.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       bin = 1'b0;
  logic       busy, done, bout;
  logic [7:0] diff;
  logic       ovf;

  logic       start3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       bin3 = 1'b0;
  logic       busy3, done3, bout3;
  logic [2:0] diff3;
  logic       ovf3;

  logic       cx = 1'b0, cy = 1'b0, cbi = 1'b0;
  logic       cd, cbo;

  int cmp = 0;
  int errs = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_sub_ctrl #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .bin(bin3),
    .busy(busy3), .done(done3), .diff(diff3), .bout(bout3)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf3)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf  = 1'b0;
  assign ovf3 = 1'b0;
`endif

  full_sub_cell u_cell (.x(cx), .y(cy), .bi(cbi), .d(cd), .bo(cbo));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a negedge where done is high; returns cycle stamp.
  task automatic wait_done(input string tag, output int at);
    int n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk({tag, "_timeout"}, 32'(done), 32'd1);
    at = cyc;
  endtask

  task automatic op8(input string tag, input logic [7:0] ai, input logic [7:0] bi_v, input logic bni,
                     input logic [7:0] ed, input logic eb, input logic eo);
    int busy_n;
    int n;
    @(negedge clk);
    a = ai; b = bi_v; bin = bni; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = busy ? 1 : 0;
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      if (busy) busy_n++;
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busycyc"}, 32'(busy_n), 32'd8);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int t1, t2, n;
    logic seen;
    logic [2:0] ed3;
    logic eb3, eo3;
    int sd;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cell truth table
    for (int i = 0; i < 8; i++) begin
      {cx, cy, cbi} = 3'(i);
      #1;
      chk("cell_d", 32'(cd), 32'(cx ^ cy ^ cbi));
      chk("cell_bo", 32'(cbo), 32'((int'(cx) - int'(cy) - int'(cbi)) < 0));
    end

    op8("op_35_12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
    op8("op_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    op8("op_10_0F_b1", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    op8("op_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

    // Start and operand changes mid-RUN are ignored
    @(negedge clk);
    a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", t1);
    chk("ignore_diff", 32'(diff), 32'h23);
    chk("ignore_bout", 32'(bout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("ignore_no_restart", 32'(busy), 32'd0);

    // Held start: one operation every WIDTH+2 cycles
    a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
    wait_done("hold1", t1);
    @(negedge clk);
    wait_done("hold2", t2);
    chk("hold_period", 32'(t2 - t1), 32'd10);
    chk("hold_diff", 32'(diff), 32'h23);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Asynchronous reset at RUN bit 4
    a = 8'h00; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_diff", 32'(diff), 32'd0);
    chk("arst_bout", 32'(bout), 32'd0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    n = 0;
    while (n < 12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    chk("arst_no_done", 32'(seen), 32'd0);
    op8("op_after_rst", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);

    // Exhaustive WIDTH=3 sweep against a reference model
    for (int bb = 0; bb < 2; bb++) begin
      for (int ai = 0; ai < 8; ai++) begin
        for (int bi_i = 0; bi_i < 8; bi_i++) begin
          @(negedge clk);
          a3 = 3'(ai); b3 = 3'(bi_i); bin3 = bb[0]; start3 = 1'b1;
          @(negedge clk);
          start3 = 1'b0;
          n = 0;
          while (done3 !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
          end
          ed3 = 3'(ai - bi_i - bb);
          eb3 = (ai < bi_i + bb);
          sd = ((ai >= 4) ? ai - 8 : ai) - ((bi_i >= 4) ? bi_i - 8 : bi_i) - bb;
          eo3 = (sd < -4) || (sd > 3);
          chk("w3_done", 32'(done3), 32'd1);
          chk("w3_diff", 32'(diff3), 32'(ed3));
          chk("w3_bout", 32'(bout3), 32'(eb3));
`ifdef SERIAL_SUB_OVF_EN
          chk("w3_ovf", 32'(ovf3), 32'(eo3));
`endif
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
